// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment driver with a serial
// double-dabble binary-to-BCD converter feeding the scan.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        load,
  input  logic        en,
  input  logic        blank_lz,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [7:0]  anode,
  output logic [6:0]  cathode
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [13:0] SAT = 14'd9999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [13:0]   r_bin, r_pend_val, w_src, w_sat;
  logic [14:0]   r_bcd;
  logic [15:0]   w_bcd_step, r_digits, w_dig_nxt;
  logic [3:0]    r_step, w_cur;
  logic          r_pend, r_ovf, w_start, w_last, w_src_ovf;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic          w_wrap, r_blank_en, w_lz;
  logic [7:0]    r_anode, w_anode_nxt;
  logic [6:0]    r_cathode;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (load || r_pend) w_state_nxt = S_CONV;
      S_CONV:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (r_state != S_IDLE) busy = 1'b1;
    if (r_state == S_DONE) done = 1'b1;
  end

  assign w_start   = (r_state == S_IDLE) && (load || r_pend);
  assign w_last    = (r_state == S_CONV) && (r_step == 4'd13);
  assign w_src     = load ? value : r_pend_val;
  assign w_src_ovf = w_src > SAT;
  assign w_sat     = w_src_ovf ? SAT : w_src;

  // Operand is capped at 9999, so the thousands nibble stays
  // below 5 before every shift and never needs correcting.
  assign w_bcd_step = {r_bcd[14:12], dd_adj(r_bcd[11:8]),
                       dd_adj(r_bcd[7:4]), dd_adj(r_bcd[3:0]),
                       r_bin[13]};
  assign w_dig_nxt  = w_last ? w_bcd_step : r_digits;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_step     <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_ovf      <= 1'b0;
      r_digits   <= '0;
    end else begin
      if (w_start) begin
        r_bin  <= w_sat;
        r_bcd  <= '0;
        r_step <= '0;
        r_ovf  <= w_src_ovf;
      end else if (r_state == S_CONV) begin
        r_bin  <= {r_bin[12:0], 1'b0};
        r_bcd  <= w_bcd_step[14:0];
        r_step <= r_step + 4'd1;
      end
      if (w_start) begin
        r_pend <= 1'b0;
      end else if (busy && load) begin
        r_pend     <= 1'b1;
        r_pend_val <= value;
      end
      r_digits <= w_dig_nxt;
    end
  end

  assign w_wrap    = (r_cnt == CNT_MAX);
  assign w_sel_nxt = w_wrap ? r_sel + 2'd1 : r_sel;
  assign w_cur     = w_dig_nxt[{w_sel_nxt, 2'b00} +: 4];

  always_comb begin
    w_lz = 1'b0;
    unique case (w_sel_nxt)
      2'd0: w_lz = 1'b0;
      2'd1: w_lz = (w_dig_nxt[15:4] == 12'd0);
      2'd2: w_lz = (w_dig_nxt[15:8] == 8'd0);
      2'd3: w_lz = (w_dig_nxt[15:12] == 4'd0);
    endcase
  end

  always_comb begin
    w_anode_nxt = 8'hFF;
    if (en && !(r_blank_en && w_lz))
      w_anode_nxt = {4'hF, ~(4'b0001 << w_sel_nxt)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_sel      <= 2'd0;
      r_blank_en <= BLANK_LZ;
      r_anode    <= 8'hFE;
      r_cathode  <= 7'h40;
    end else begin
      r_cnt      <= w_wrap ? '0 : r_cnt + CW'(1);
      r_sel      <= w_sel_nxt;
      r_blank_en <= blank_lz;
      r_anode    <= w_anode_nxt;
      r_cathode  <= seg7(w_cur);
    end
  end

  assign ovf     = r_ovf;
  assign anode   = r_anode;
  assign cathode = r_cathode;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short refresh period
// so every scan slot is reached within a few dozen cycles.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, load, en, blank_lz;
  logic [13:0] value;
  logic        busy, done, ovf;
  logic [7:0]  anode;
  logic [6:0]  cathode;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg7_scan_ctrl #(
    .REFRESH_DIV(4),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .load(load),
    .en(en),
    .blank_lz(blank_lz),
    .busy(busy),
    .done(done),
    .ovf(ovf),
    .anode(anode),
    .cathode(cathode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (reset) cyc = 0;
    else cyc++;
    #1;
  endtask

  function automatic int msel();
    return (cyc >> 2) & 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_an(input int s, input bit blank);
    logic [7:0] r;
    r = 8'hFF;
    if (!blank) r[s] = 1'b0;
    return r;
  endfunction

  task automatic show_all(input string tag,
                          input logic [6:0] c0, input logic [6:0] c1,
                          input logic [6:0] c2, input logic [6:0] c3,
                          input logic [3:0] blk);
    logic [6:0] c[4];
    c = '{c0, c1, c2, c3};
    for (int s = 0; s < 4; s++) begin
      do tick(); while (msel() != s);
      chk($sformatf("%s_an%0d", tag, s), 32'(anode), 32'(exp_an(s, blk[s])));
      chk($sformatf("%s_ca%0d", tag, s), 32'(cathode), 32'(c[s]));
    end
  endtask

  task automatic run_conv(input string tag, input logic [13:0] v,
                          input logic exp_ovf);
    int nd;
    nd = 0;
    value = v;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (15) begin
      tick();
      if (done === 1'b1) nd++;
    end
    chk({tag, "_ndone"}, 32'(nd), 32'(1));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int nd, d1, d2;
    reset    = 1'b1;
    load     = 1'b0;
    en       = 1'b1;
    blank_lz = 1'b1;
    value    = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    chk("rst_an", 32'(anode), 32'('hFE));
    chk("rst_ca", 32'(cathode), 32'('h40));

    // 1234: busy for 15 cycles, done 14 edges after load
    value = 14'd1234;
    load  = 1'b1;
    tick();
    load = 1'b0;
    chk("c_busy0", 32'(busy), 32'(1));
    chk("c_done0", 32'(done), 32'(0));
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk($sformatf("c_busy%0d", i), 32'(busy), 32'(1));
      chk($sformatf("c_done%0d", i), 32'(done), 32'(i == 14));
    end
    tick();
    chk("c_busy15", 32'(busy), 32'(0));
    chk("c_done15", 32'(done), 32'(0));
    chk("c_ovf", 32'(ovf), 32'(0));
    show_all("d1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);

    // leading-zero blanking on and off
    run_conv("v7", 14'd7, 1'b0);
    show_all("lz1", 7'h78, 7'h40, 7'h40, 7'h40, 4'b1110);
    blank_lz = 1'b0;
    show_all("lz0", 7'h78, 7'h40, 7'h40, 7'h40, 4'b0000);

    // saturation then recovery
    run_conv("v12000", 14'd12000, 1'b1);
    show_all("sat", 7'h10, 7'h10, 7'h10, 7'h10, 4'b0000);
    run_conv("v5", 14'd5, 1'b0);
    show_all("five", 7'h12, 7'h40, 7'h40, 7'h40, 4'b0000);

    // pending load during busy
    blank_lz = 1'b1;
    value = 14'd100;
    load  = 1'b1;
    tick();
    load = 1'b0;
    nd = 0;
    d1 = -1;
    d2 = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 3) begin
        value = 14'd200;
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) d1 = n;
        else if (nd == 2) d2 = n;
      end
      if (n == 15) chk("p_idle", 32'(busy), 32'(0));
      if (n == 16) chk("p_restart", 32'(busy), 32'(1));
    end
    chk("p_ndone", 32'(nd), 32'(2));
    chk("p_d1", 32'(d1), 32'(14));
    chk("p_d2", 32'(d2), 32'(30));
    show_all("d200", 7'h40, 7'h40, 7'h24, 7'h40, 4'b1000);

    // reset in the middle of a conversion
    value = 14'd12000;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ra_busy", 32'(busy), 32'(0));
    chk("ra_done", 32'(done), 32'(0));
    chk("ra_ovf", 32'(ovf), 32'(0));
    chk("ra_an", 32'(anode), 32'('hFE));
    chk("ra_ca", 32'(cathode), 32'('h40));
    nd = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) nd++;
    end
    chk("ra_ndone", 32'(nd), 32'(0));
    show_all("ra", 7'h40, 7'h40, 7'h40, 7'h40, 4'b1110);

    // display enable off keeps scanning underneath
    blank_lz = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("en0_%0d", i), 32'(anode), 32'('hFF));
    end
    en = 1'b1;
    tick();
    chk("en1_an", 32'(anode), 32'(exp_an(msel(), 1'b0)));
    show_all("en", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
